factorial_calc: RTL and testbench

- Sequential factorial engine: computes N! for a 4-bit unsigned operand and returns a 32-bit result.
- Iterative design: one 32x4 multiply per clock, with a start/done handshake and an overflow flag.
- Utility arithmetic block behind any controller needing small factorials (combinatorics, normalisation constants).

---
 rtl/factorial_pkg.sv | 11 +
 rtl/fact_mul_32x4.sv | 16 +
 rtl/factorial_calc.sv | 93 +++++++++
 tb/tb_factorial_calc.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
// factorial_pkg: shared widths, FSM state type and limits for the factorial engine.
//   DEF_IN_W / DEF_OUT_W : default operand and result widths
//   MAX_EXACT_N          : largest N whose factorial fits in DEF_OUT_W bits
//   SAT_VALUE            : result reported on overflow when saturation is built in
package factorial_pkg;
    localparam int DEF_IN_W = 4;
    localparam int DEF_OUT_W = 32;
    localparam int MAX_EXACT_N = 12;
    localparam logic [31:0] SAT_VALUE = 32'hFFFF_FFFF;
    typedef enum logic {IDLE, CALC} state_t;
endpackage

// File: rtl/fact_mul_32x4.sv
// fact_mul_32x4: combinational unsigned multiply of the accumulator by the countdown value.
//   a : A_W-bit multiplicand (accumulator)
//   b : B_W-bit multiplier (count)
//   p : full A_W+B_W-bit product; bits above A_W-1 signal overflow
module fact_mul_32x4
    import factorial_pkg::*;
#(
    parameter int A_W = DEF_OUT_W,
    parameter int B_W = DEF_IN_W
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);
    assign p = (A_W+B_W)'(a) * (A_W+B_W)'(b);
endmodule

// File: rtl/factorial_calc.sv
// factorial_calc: iterative N! engine, one multiply per clock, start/done handshake.
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   start    : request, accepted only when idle; number captured with it
//   number   : operand N
//   out      : result, held until the next completion
//   done     : one-cycle pulse when out/overflow are updated
//   busy     : high while computing
//   overflow : true N! does not fit in OUT_W bits
// Build option FACTORIAL_SAT_EN: report SAT_VALUE in out when overflow is set.
module factorial_calc
    import factorial_pkg::*;
#(
    parameter int IN_W = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  number,
    output logic [OUT_W-1:0] out,
    output logic             done,
    output logic             busy,
    output logic             overflow
);
    state_t state, state_n;
    logic [OUT_W-1:0] acc, acc_n, out_n, fin;
    logic [IN_W-1:0] cnt, cnt_n;
    logic ovf_int, ovf_n, overflow_n, done_n;
    logic [OUT_W+IN_W-1:0] prod;

    fact_mul_32x4 #(.A_W(OUT_W), .B_W(IN_W)) u_mul (
        .a(acc),
        .b(cnt),
        .p(prod)
    );

`ifdef FACTORIAL_SAT_EN
    assign fin = ovf_int ? OUT_W'(SAT_VALUE) : acc;
`else
    assign fin = acc;
`endif

    assign busy = (state == CALC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= OUT_W'(1);
            cnt      <= '0;
            ovf_int  <= 1'b0;
            out      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            ovf_int  <= ovf_n;
            out      <= out_n;
            done     <= done_n;
            overflow <= overflow_n;
        end
    end

    // Counting down from N to 2 means 0! and 1! finish on the first CALC cycle with acc=1.
    always_comb begin
        state_n    = state;
        acc_n      = acc;
        cnt_n      = cnt;
        ovf_n      = ovf_int;
        out_n      = out;
        overflow_n = overflow;
        done_n     = 1'b0;
        if (state == IDLE) begin
            if (start) begin
                state_n = CALC;
                acc_n   = OUT_W'(1);
                cnt_n   = number;
                ovf_n   = 1'b0;
            end
        end else if (cnt <= IN_W'(1)) begin
            state_n    = IDLE;
            out_n      = fin;
            overflow_n = ovf_int;
            done_n     = 1'b1;
        end else begin
            acc_n = prod[OUT_W-1:0];
            ovf_n = ovf_int | (prod[OUT_W+IN_W-1:OUT_W] != '0);
            cnt_n = cnt - IN_W'(1);
        end
    end
endmodule

// File: tb/tb_factorial_calc.sv
// tb_factorial_calc: scoreboard-driven self-checking bench for factorial_calc.
module tb_factorial_calc;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic [3:0] number;
    logic [31:0] res;
    logic done, busy, overflow;

    typedef struct {
        logic [31:0] val;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    factorial_calc dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .number(number),
        .out(res),
        .done(done),
        .busy(busy),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] true_fact(input int n);
        logic [63:0] f = 64'd1;
        for (int i = 2; i <= n; i++) f = f * 64'(i);
        return f;
    endfunction

    task automatic start_op(input logic [3:0] n);
        exp_t e;
        logic [63:0] f;
        f = true_fact(int'(n));
        e.ovf = f > 64'hFFFF_FFFF;
`ifdef FACTORIAL_SAT_EN
        e.val = e.ovf ? 32'hFFFF_FFFF : f[31:0];
`else
        e.val = f[31:0];
`endif
        e.lat = (n <= 4'd1) ? 1 : int'(n);
        sb.push_back(e);
        start = 1'b1;
        number = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int repulse, output int cyc, output int bcnt);
        cyc = -1;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == repulse) begin
                start = 1'b1;
                number = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) begin
                cyc = i;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        number = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", res); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_small();
        int cyc, bc;
        exp_t e;
        for (int n = 0; n <= 6; n++) begin
            start_op(4'(n));
            wait_done(-1, cyc, bc);
            e = sb.pop_front();
            checks++; if (cyc !== e.lat) begin errors++; $display("FAIL small_lat n=%0d: got %0d want %0d", n, cyc, e.lat); end
            checks++; if (res !== e.val) begin errors++; $display("FAIL small_out n=%0d: got %0d want %0d", n, res, e.val); end
            checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL small_ovf n=%0d: got %b want %b", n, overflow, e.ovf); end
        end
    endtask

    task automatic test_boundary();
        int cyc, bc;
        exp_t e;
        logic [31:0] want13;
`ifdef FACTORIAL_SAT_EN
        want13 = 32'hFFFF_FFFF;
`else
        want13 = 32'd1932053504;
`endif
        start_op(4'd12);
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        checks++; if (cyc !== 12) begin errors++; $display("FAIL n12_lat: got %0d want 12", cyc); end
        checks++; if (res !== 32'd479001600) begin errors++; $display("FAIL n12_out: got %0d want 479001600", res); end
        checks++; if (overflow !== e.ovf) begin errors++; $display("FAIL n12_ovf: got %b want %b", overflow, e.ovf); end
        start_op(4'd13);
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        checks++; if (res !== want13) begin errors++; $display("FAIL n13_out: got %0d want %0d", res, want13); end
        checks++; if (res !== e.val) begin errors++; $display("FAIL n13_model: got %0d want %0d", res, e.val); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL n13_ovf: got %b want 1", overflow); end
    endtask

    task automatic test_ignore_start();
        int cyc, bc, total;
        exp_t e;
        start_op(4'd15);
        total = busy ? 1 : 0;
        wait_done(3, cyc, bc);
        total += bc;
        e = sb.pop_front();
        checks++; if (cyc !== 15) begin errors++; $display("FAIL n15_lat: got %0d want 15", cyc); end
        checks++; if (total !== 15) begin errors++; $display("FAIL n15_busy: got %0d want 15", total); end
        checks++; if (res !== e.val) begin errors++; $display("FAIL n15_out: got %0d want %0d", res, e.val); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL n15_ovf: got %b want 1", overflow); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL n15_idle_after: got %b want 0", busy); end
    endtask

    task automatic test_reset_abort();
        int cyc, bc, seen;
        exp_t e;
        start_op(4'd6);
        e = sb.pop_back();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (res !== 32'd0) begin errors++; $display("FAIL abort_out: got %0d want 0", res); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf: got %b want 0", overflow); end
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        start_op(4'd4);
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        checks++; if (res !== 32'd24) begin errors++; $display("FAIL abort_next_out: got %0d want 24", res); end
        checks++; if (cyc !== e.lat) begin errors++; $display("FAIL abort_next_lat: got %0d want %0d", cyc, e.lat); end
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        exp_t e;
        start_op(4'd3);
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        checks++; if (res !== 32'd6) begin errors++; $display("FAIL b2b_first_out: got %0d want 6", res); end
        checks++; if (cyc !== e.lat) begin errors++; $display("FAIL b2b_first_lat: got %0d want %0d", cyc, e.lat); end
        start_op(4'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
        wait_done(-1, cyc, bc);
        e = sb.pop_front();
        checks++; if (cyc !== 4) begin errors++; $display("FAIL b2b_second_lat: got %0d want 4", cyc); end
        checks++; if (res !== e.val) begin errors++; $display("FAIL b2b_second_out: got %0d want %0d", res, e.val); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_second_ovf: got %b want 0", overflow); end
    endtask

    initial begin
        test_reset();
        test_small();
        test_boundary();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
